// File: rtl/npc_pkg.sv
// Default geometry shared by the NPC core register file and its scoreboard.
package npc_pkg;

  localparam int NPC_ADDR_WIDTH = 5;
  localparam int NPC_DATA_WIDTH = 32;
  localparam int NPC_NREAD      = 2;
  localparam int NPC_PEND_W     = 2;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down count of outstanding writes to one register.
module pend_counter
  import npc_pkg::*;
#(
  parameter int PEND_W = NPC_PEND_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic is_one,
  output logic full
);

  logic [PEND_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel; clr dominates both.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !dec && !full)
      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc && nonzero)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign nonzero = |cnt_q;
  assign is_one  = (cnt_q == PEND_W'(1));
  assign full    = &cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, optional write-to-read bypass
// and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_scoreboard
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
  parameter int DATA_WIDTH = NPC_DATA_WIDTH,
  parameter int NREAD      = NPC_NREAD,
  parameter int BYPASS     = 1,
  parameter int PEND_W     = NPC_PEND_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
  output logic [NREAD*DATA_WIDTH-1:0] rdata,
  output logic [NREAD-1:0]            rbusy,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  output logic                        iss_ready,
  input  logic                        we,
  input  logic [ADDR_WIDTH-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        flush
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [NREG];
  logic [NREG-1:0]       pend_nz, pend_one, pend_full;
  logic                  acc, ret;

  // Register 0 has no counter; its flags read as an idle, never-full entry.
  assign pend_nz[0]   = 1'b0;
  assign pend_one[0]  = 1'b0;
  assign pend_full[0] = 1'b0;

  assign iss_ready = (iss_rd == '0) || !pend_full[iss_rd];
  assign acc       = iss_valid && iss_ready && (iss_rd != '0) && !flush;
  assign ret       = we && (waddr != '0) && pend_nz[waddr] && !flush;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    pend_counter #(.PEND_W(PEND_W)) u_pend (
      .clk     (clk),
      .rst     (rst),
      .inc     (acc && (iss_rd == ADDR_WIDTH'(r))),
      .dec     (ret && (waddr == ADDR_WIDTH'(r))),
      .clr     (flush),
      .nonzero (pend_nz[r]),
      .is_one  (pend_one[r]),
      .full    (pend_full[r])
    );
  end

  // Write-back data commits even under flush; only the scoreboard is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++)
        mem_q[k] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;

    assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit = (BYPASS != 0) && we && (waddr == ra) && (ra != '0);

    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 :
                                               (hit ? wdata : mem_q[ra]);
    // The last outstanding write arriving now is forwarded, so not busy.
    assign rbusy[i] = pend_nz[ra] && !(hit && pend_one[ra]);
  end

endmodule
